sha256_word_unpack: RTL and testbench
=====================================

Name: sha256_word_unpack

Overview:
- Upstream feeder for the 16-bit-wide enable/reset register stages of the sha256crypt core.
- Accepts 32-bit message words over a valid/ready handshake and emits each word as two 16-bit halves, high half first.
- Drives the half-word data and a one-cycle load enable into the downstream registers.
- Tracks the word index within a 16-word SHA-256 block and flags block completion.

Parameters:
- N, 16, half-word width; input word width is 2*N.
- WORDS, 16, words per block; must be a power of two, at most 16.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  2*N  message word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- out_ready  input  1  downstream can load a half-word this cycle.
- out_data  output  N  current half-word.
- out_en  output  1  half-word transfer this cycle; drives downstream register en.
- out_hi  output  1  1 = out_data is the high half.
- out_idx  output  4  index of the word being emitted, 0..WORDS-1.
- blk_done  output  1  one-cycle pulse on the low-half transfer of word WORDS-1.

Behaviour:
- Reset:
  - While rst=1: state=IDLE, hold register=0, word counter=0.
  - Outputs while rst=1: in_ready=0, out_en=0, out_data=0, out_hi=0, out_idx=0, blk_done=0.
  - Reset mid-operation drops any partially emitted word; no half-word is emitted after reset until a new word is accepted.
- States:
  - IDLE: no word held.
  - HI: word held, high half pending.
  - LO: low half pending.
- Input accept: a word is accepted on any edge with in_valid & in_ready. The word is latched into the hold register.
- in_ready (combinational, forced 0 during rst): 1 in IDLE, or in LO with out_ready=1. Always 0 in HI.
- Transitions:
  - IDLE -> HI on accept.
  - HI -> LO when out_ready=1; otherwise stay in HI.
  - LO with out_ready=1 and accept: -> HI with the new word. This back-to-back case sustains 1 word per 2 cycles with no bubble.
  - LO with out_ready=1 and no accept: -> IDLE.
  - LO with out_ready=0: stay in LO; in_ready=0.
- Outputs:
  - out_data = hold[2N-1:N] in HI, hold[N-1:0] in LO, and holds its last value in IDLE.
  - out_hi = 1 only in HI.
  - out_en = (HI or LO) & out_ready. out_en is never asserted in IDLE.
  - out_data must be stable whenever out_en=1.
- Latency: a word accepted at edge t gives its high half on out_data during cycle t+1. The low half follows in cycle t+2 at the earliest.
- Word counter:
  - Increments on each low-half transfer (LO & out_ready).
  - Wraps from WORDS-1 to 0.
  - out_idx equals the counter value.
- blk_done = LO & out_ready & (counter == WORDS-1). It is combinational and coincides with that out_en.
- Backpressure: out_ready may drop in any state. State, data, and index freeze until it returns, and no half-word is lost or duplicated.

Optional Feature:
- Macro: SHA256_UNPACK_BSWAP_EN.
- Defined: the accepted word is byte-reversed before latching (bytes 3,2,1,0 -> 0,1,2,3), so little-endian host words reach the core big-endian. Applies only when N=16.
- Undefined: the word is latched unmodified.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, then one word 0xDEADBEEF with out_ready=1 held high.
  - Required: cycle t+1: out_en=1, out_hi=1, out_data=0xDEAD. Cycle t+2: out_data=0xBEEF, out_hi=0. Cycle t+3: out_en=0.
- 16 back-to-back words 0x00010002+k, in_valid and out_ready both held at 1.
  - Required: exactly 32 out_en pulses and no bubbles; in_ready pulses every second cycle.
  - Required: out_idx steps 0..15; a single blk_done coincides with out_data=0x0011 (low half of word 15); out_idx then returns to 0.
- Backpressure: out_ready=0 for 5 cycles while in HI with word 0x12345678.
  - Required: out_data holds 0x1234, out_en=0, and in_ready=0 throughout.
  - Required: after release, 0x1234 is emitted once, then 0x5678.
- rst asserted while in LO with word 0xCAFEF00D.
  - Required: no 0xF00D transfer occurs; next cycle all outputs are 0 and out_idx=0; in_ready returns after rst deasserts.
- 17 words, sent after a 15-word run.
  - Required: blk_done fires on word 15 only and the count wraps to 0.
- With SHA256_UNPACK_BSWAP_EN defined, word 0x11223344.
  - Required: 0x4433 is emitted, then 0x2211.
  - Required: without the macro, the same word gives 0x1122 then 0x3344.

Source files
------------

// File: rtl/sha256_word_unpack.sv
// Splits 32-bit message words into two half-words (high first) for the sha256crypt register stages.
// Optional build macro SHA256_UNPACK_BSWAP_EN byte-reverses each accepted word (N=16 only).
module sha256_word_unpack #(
    parameter int N     = 16,
    parameter int WORDS = 16
) (
    input  logic           CLK,
    input  logic           rst,
    input  logic [2*N-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic           out_en,
    output logic           out_hi,
    output logic [3:0]     out_idx,
    output logic           blk_done
);

    // state | meaning
    // IDLE  | no word held
    // HI    | word held, high half pending
    // LO    | low half pending
    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    localparam logic [3:0] LAST = 4'(WORDS - 1);

    state_t         state_q, state_d;
    logic [2*N-1:0] hold_q, hold_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [2*N-1:0] word_in;
    logic           accept;
    logic           lo_xfer;

`ifdef SHA256_UNPACK_BSWAP_EN
    localparam int BYTES = (2 * N) / 8;

    // Little-endian host words are reversed so the core sees them big-endian.
    always_comb begin
        word_in = in_data;
        if (N == 16) begin
            for (int i = 0; i < BYTES; i++) begin
                word_in[8*i +: 8] = in_data[8*(BYTES-1-i) +: 8];
            end
        end
    end
`else
    assign word_in = in_data;
`endif

    always_comb begin
        in_ready = !rst && ((state_q == IDLE) || ((state_q == LO) && out_ready));
        accept   = in_valid && in_ready;
        lo_xfer  = (state_q == LO) && out_ready;

        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE:    if (accept) state_d = HI;
            HI:      if (out_ready) state_d = LO;
            LO:      if (out_ready) state_d = accept ? HI : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) hold_d = word_in;
        if (lo_xfer) cnt_d = (cnt_q == LAST) ? 4'd0 : cnt_q + 4'd1;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // IDLE keeps showing the low half, which is the last value driven.
    always_comb begin
        out_hi   = !rst && (state_q == HI);
        out_en   = !rst && ((state_q == HI) || (state_q == LO)) && out_ready;
        out_data = rst ? '0 : ((state_q == HI) ? hold_q[2*N-1:N] : hold_q[N-1:0]);
        out_idx  = rst ? 4'd0 : cnt_q;
        blk_done = !rst && lo_xfer && (cnt_q == LAST);
    end

endmodule

// File: tb/tb_sha256_word_unpack.sv
// Bench for sha256_word_unpack: vector table with latency checks plus a half-word scoreboard.
module tb_sha256_word_unpack;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_en;
    logic        out_hi;
    logic [3:0]  out_idx;
    logic        blk_done;

    sha256_word_unpack #(.N(16), .WORDS(16)) dut (
        .CLK(CLK), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_data(out_data), .out_en(out_en), .out_hi(out_hi),
        .out_idx(out_idx), .blk_done(blk_done)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef SHA256_UNPACK_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    typedef struct packed {
        logic [15:0] d;
        logic        hi;
    } half_t;

    half_t       sb[$];
    int          m_idx = 0;
    int          en_cnt = 0;
    int          done_cnt = 0;
    int          acc_cnt = 0;
    int          streak = 0;
    int          last_streak = 0;
    logic [15:0] done_data = '0;

    always @(negedge CLK) begin
        half_t       e;
        logic [31:0] w;
        logic        exp_done;
        if (rst) begin
            sb.delete();
            m_idx = 0;
            chk("rst_no_en", {31'd0, out_en}, 32'd0);
        end else begin
            if (out_en) begin
                en_cnt++;
                streak++;
                if (blk_done) begin
                    done_cnt++;
                    done_data = out_data;
                end
                if (sb.size() == 0) begin
                    chk("spurious_en", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    exp_done = !e.hi && (m_idx == 15);
                    chk("sb_data", {16'd0, out_data}, {16'd0, e.d});
                    chk("sb_hi", {31'd0, out_hi}, {31'd0, e.hi});
                    chk("sb_idx", {28'd0, out_idx}, 32'(m_idx));
                    chk("sb_done", {31'd0, blk_done}, {31'd0, exp_done});
                    if (!e.hi) m_idx = (m_idx + 1) % 16;
                end
            end else begin
                if (streak != 0) last_streak = streak;
                streak = 0;
                if (blk_done) chk("done_without_en", 32'd1, 32'd0);
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                w = xf(in_data);
                sb.push_back('{d: w[31:16], hi: 1'b1});
                sb.push_back('{d: w[15:0],  hi: 1'b0});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_hi", {31'd0, out_hi}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
        chk("rst_blk_done", {31'd0, blk_done}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        step();
    endtask

    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
        step();
    endtask

    typedef struct {
        logic [31:0] w;
        logic [15:0] hi;
        logic [15:0] lo;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   en0, done0, acc0;
`ifdef SHA256_UNPACK_BSWAP_EN
        vecs[0] = '{32'hDEADBEEF, 16'hEFBE, 16'hADDE};
        vecs[1] = '{32'h11223344, 16'h4433, 16'h2211};
        vecs[2] = '{32'h00000000, 16'h0000, 16'h0000};
        vecs[3] = '{32'hFFFF0001, 16'h0100, 16'hFFFF};
        vecs[4] = '{32'h12345678, 16'h7856, 16'h3412};
`else
        vecs[0] = '{32'hDEADBEEF, 16'hDEAD, 16'hBEEF};
        vecs[1] = '{32'h11223344, 16'h1122, 16'h3344};
        vecs[2] = '{32'h00000000, 16'h0000, 16'h0000};
        vecs[3] = '{32'hFFFF0001, 16'hFFFF, 16'h0001};
        vecs[4] = '{32'h12345678, 16'h1234, 16'h5678};
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        do_reset();

        // single words with latency checks
        for (int i = 0; i < 5; i++) begin
            in_data  = vecs[i].w;
            in_valid = 1'b1;
            @(negedge CLK);
            chk("vec_ready", {31'd0, in_ready}, 32'd1);
            step();
            in_valid = 1'b0;
            @(negedge CLK);
            chk("vec_t1_en", {31'd0, out_en}, 32'd1);
            chk("vec_t1_hi", {31'd0, out_hi}, 32'd1);
            chk("vec_t1_data", {16'd0, out_data}, {16'd0, vecs[i].hi});
            step();
            @(negedge CLK);
            chk("vec_t2_en", {31'd0, out_en}, 32'd1);
            chk("vec_t2_hi", {31'd0, out_hi}, 32'd0);
            chk("vec_t2_data", {16'd0, out_data}, {16'd0, vecs[i].lo});
            step();
            @(negedge CLK);
            chk("vec_t3_en", {31'd0, out_en}, 32'd0);
            chk("vec_t3_hold", {16'd0, out_data}, {16'd0, vecs[i].lo});
            step();
        end

        // 16 back-to-back words
        do_reset();
        en0 = en_cnt; done0 = done_cnt; acc0 = acc_cnt;
        for (int k = 0; k < 16; k++) send_word(32'h00010002 + k);
        in_valid = 1'b0;
        repeat (4) step();
        chk("b2b_en_count", 32'(en_cnt - en0), 32'd32);
        chk("b2b_no_bubble", 32'(last_streak), 32'd32);
        chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd16);
        chk("b2b_done_count", 32'(done_cnt - done0), 32'd1);
        begin
            logic [31:0] w15;
            w15 = xf(32'h00010011);
            chk("b2b_done_data", {16'd0, done_data}, {16'd0, w15[15:0]});
        end
        chk("b2b_idx_wrap", {28'd0, out_idx}, 32'd0);

        // backpressure while in HI
        do_reset();
        en0 = en_cnt;
        send_word(32'h12345678);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("bp_data", {16'd0, out_data}, {16'd0, vecs[4].hi});
            chk("bp_en", {31'd0, out_en}, 32'd0);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();
        chk("bp_en_count", 32'(en_cnt - en0), 32'd2);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // reset while in LO
        do_reset();
        en0 = en_cnt;
        send_word(32'hCAFEF00D);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        @(negedge CLK);
        chk("rlo_en", {31'd0, out_en}, 32'd0);
        step();
        @(negedge CLK);
        chk("rlo_data", {16'd0, out_data}, 32'd0);
        chk("rlo_idx", {28'd0, out_idx}, 32'd0);
        chk("rlo_hi", {31'd0, out_hi}, 32'd0);
        chk("rlo_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge CLK);
        chk("rlo_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        repeat (3) step();
        chk("rlo_en_count", 32'(en_cnt - en0), 32'd1);

        // 15-word run, gap, then 17 words
        do_reset();
        done0 = done_cnt;
        for (int k = 0; k < 15; k++) send_word(32'hA5000000 + k);
        in_valid = 1'b0;
        repeat (3) step();
        chk("run15_no_done", 32'(done_cnt - done0), 32'd0);
        chk("run15_idx", {28'd0, out_idx}, 32'd15);
        for (int k = 0; k < 17; k++) send_word(32'h5A000000 + k);
        in_valid = 1'b0;
        repeat (4) step();
        chk("run32_done_count", 32'(done_cnt - done0), 32'd2);
        chk("run32_idx_wrap", {28'd0, out_idx}, 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
